// File: rtl/ravenoc_pkg.sv
// Shared types and constants for the RaveNoC router input stage.
package ravenoc_pkg;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_t;

  localparam int ROUTE_W = 5;

  localparam logic [ROUTE_W-1:0] ROUTE_NORTH = 5'b00001;
  localparam logic [ROUTE_W-1:0] ROUTE_SOUTH = 5'b00010;
  localparam logic [ROUTE_W-1:0] ROUTE_WEST  = 5'b00100;
  localparam logic [ROUTE_W-1:0] ROUTE_EAST  = 5'b01000;
  localparam logic [ROUTE_W-1:0] ROUTE_LOCAL = 5'b10000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } in_state_t;

endpackage

// File: rtl/ravenoc_fifo.sv
// Synchronous FIFO with occupancy output; read data reads as zero while empty.
module ravenoc_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are don't-care until covered by the level count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ravenoc_input_unit.sv
// Router input port: flit buffer, packet framing FSM and XY route request.
// Optional framing-error detection/drop enabled by defining RAVENOC_INPUT_ERR_EN.
module ravenoc_input_unit
  import ravenoc_pkg::*;
#(
  parameter int FLIT_WIDTH  = 34,
  parameter int FIFO_DEPTH  = 4,
  parameter int X_W         = 2,
  parameter int Y_W         = 2,
  parameter int ROUTER_X_ID = 0,
  parameter int ROUTER_Y_ID = 0
) (
  input  logic                              clk_noc,
  input  logic                              arst_noc,
  input  logic                              in_valid,
  input  logic [FLIT_WIDTH-1:0]             in_flit,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [FLIT_WIDTH-1:0]             out_flit,
  output logic [ROUTE_W-1:0]                out_route,
  input  logic                              out_ready,
  output logic                              pkt_active,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              err_proto
);

  localparam logic [X_W-1:0] MY_X = X_W'(ROUTER_X_ID);
  localparam logic [Y_W-1:0] MY_Y = Y_W'(ROUTER_Y_ID);

  logic [FLIT_WIDTH-1:0] head_flit;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  fwd_pop;
  logic                  drop;
  logic                  is_start;
  flit_type_t            head_type;
  logic [X_W-1:0]        dest_x;
  logic [Y_W-1:0]        dest_y;
  logic [ROUTE_W-1:0]    xy_route;
  logic [ROUTE_W-1:0]    route_q;
  logic [ROUTE_W-1:0]    route_d;
  in_state_t             state_q;
  in_state_t             state_d;

  assign in_ready = arst_noc && !fifo_full;
  assign push     = in_valid && in_ready;

  ravenoc_fifo #(
    .WIDTH (FLIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_noc),
    .rst_n   (arst_noc),
    .push    (push),
    .wr_data (in_flit),
    .pop     (pop),
    .rd_data (head_flit),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_type = flit_type_t'(head_flit[FLIT_WIDTH-1 -: 2]);
  assign is_start  = (head_type == FLIT_HEAD) || (head_type == FLIT_HEAD_TAIL);
  assign dest_x    = head_flit[X_W+Y_W-1:Y_W];
  assign dest_y    = head_flit[Y_W-1:0];

`ifdef RAVENOC_INPUT_ERR_EN
  // Orphan body/tail flits outside a packet are discarded without being offered.
  assign drop = !fifo_empty && (state_q == ST_IDLE) && !is_start;
`else
  assign drop = 1'b0;
`endif

  assign out_valid  = !fifo_empty && !drop;
  assign out_flit   = head_flit;
  assign fwd_pop    = out_valid && out_ready;
  assign pop        = fwd_pop || drop;
  assign pkt_active = (state_q == ST_PKT);

  // XY dimension-order route, rows resolved before columns.
  always_comb begin
    xy_route = ROUTE_LOCAL;
    if (dest_x < MY_X)      xy_route = ROUTE_NORTH;
    else if (dest_x > MY_X) xy_route = ROUTE_SOUTH;
    else if (dest_y < MY_Y) xy_route = ROUTE_WEST;
    else if (dest_y > MY_Y) xy_route = ROUTE_EAST;
  end

  // Framing FSM: next state, route latch and route request.
  always_comb begin
    state_d   = state_q;
    route_d   = route_q;
    out_route = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (out_valid) begin
          if (is_start) begin
            out_route = xy_route;
            if (fwd_pop && head_type == FLIT_HEAD) begin
              state_d = ST_PKT;
              route_d = xy_route;
            end
          end else begin
            out_route = route_q;
          end
        end
      end
      ST_PKT: begin
        if (out_valid) begin
          out_route = route_q;
          if (fwd_pop && head_type == FLIT_TAIL) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched route registers.
  always_ff @(posedge clk_noc) begin
    if (!arst_noc) begin
      state_q <= ST_IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

`ifdef RAVENOC_INPUT_ERR_EN
  logic err_q;
  // Sticky framing error: dropped orphan flits or a packet start inside a packet.
  always_ff @(posedge clk_noc) begin
    if (!arst_noc) begin
      err_q <= 1'b0;
    end else if (drop || (fwd_pop && state_q == ST_PKT && is_start)) begin
      err_q <= 1'b1;
    end
  end
  assign err_proto = err_q;
`else
  assign err_proto = 1'b0;
`endif

endmodule
